// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register.
// Captures everything the memory stage consumes from EX: store data, ALU result/address,
// PC+2, jump offset, memory controls, branch/jump selects and writeback controls.
// It supports stall (hold), flush (bubble) and a sticky halt latch, and keeps a saturating
// count of stalled cycles for performance debug.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-low reset
//   stall, flush   hold all outputs / load a bubble (flush wins)
//   ex_*           incoming EX-stage entry
//   mem_*          registered entry presented to the memory stage
//   halted         sticky: a valid halt has entered the memory stage
//   stall_cnt      saturating count of edges with stall=1, flush=0, mem_valid=1
module ex_mem_reg #(
  parameter int unsigned       WIDTH    = 16,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_alu,
  input  logic [WIDTH-1:0] ex_wdata,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic [WIDTH-1:0] ex_jmpsrc,
  input  logic             ex_memen,
  input  logic             ex_memwr,
  input  logic             ex_halt,
  input  logic             ex_brchcnd,
  input  logic             ex_alujmp,
  input  logic             ex_setrd,
  input  logic             ex_regsrc,
  input  logic             ex_regwr,
  input  logic [2:0]       ex_wreg,
  output logic             mem_valid,
  output logic [WIDTH-1:0] mem_alu,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [WIDTH-1:0] mem_pc,
  output logic [WIDTH-1:0] mem_jmpsrc,
  output logic             mem_memen,
  output logic             mem_memwr,
  output logic             mem_halt,
  output logic             mem_brchcnd,
  output logic             mem_alujmp,
  output logic             mem_setrd,
  output logic             mem_regsrc,
  output logic             mem_regwr,
  output logic [2:0]       mem_wreg,
  output logic             halted,
  output logic [15:0]      stall_cnt
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] jmpsrc;
    logic             memen;
    logic             memwr;
    logic             halt;
    logic             brchcnd;
    logic             alujmp;
    logic             setrd;
    logic             regsrc;
    logic             regwr;
    logic [2:0]       wreg;
  } entry_t;

  localparam entry_t ResetEntry = '{pc: RESET_PC, default: '0};

  entry_t      entry_d, entry_q;
  entry_t      ex_entry;
  logic        halted_d, halted_q;
  logic [15:0] cnt_d, cnt_q;

  always_comb begin
    ex_entry         = '0;
    ex_entry.valid   = ex_valid;
    ex_entry.alu     = ex_alu;
    ex_entry.wdata   = ex_wdata;
    ex_entry.pc      = ex_pc;
    ex_entry.jmpsrc  = ex_jmpsrc;
    ex_entry.memen   = ex_memen;
    ex_entry.memwr   = ex_memwr;
    ex_entry.halt    = ex_halt;
    ex_entry.brchcnd = ex_brchcnd;
    ex_entry.alujmp  = ex_alujmp;
    ex_entry.setrd   = ex_setrd;
    ex_entry.regsrc  = ex_regsrc;
    ex_entry.regwr   = ex_regwr;
    ex_entry.wreg    = ex_wreg;
  end

  // Priority: flush > stall > halted-block > load. A bubble is all-zero, which keeps every
  // control output low whenever mem_valid is low.
  always_comb begin
    entry_d  = entry_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    if (flush) begin
      entry_d = '0;
    end else if (stall) begin
      if (entry_q.valid && (cnt_q != 16'hFFFF)) begin
        cnt_d = cnt_q + 16'd1;
      end
    end else if (halted_q) begin
      entry_d = '0;
    end else if (ex_valid) begin
      entry_d = ex_entry;
      if (ex_halt) begin
        halted_d = 1'b1;
      end
    end else begin
      entry_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_q  <= ResetEntry;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      entry_q  <= entry_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mem_valid   = entry_q.valid;
  assign mem_alu     = entry_q.alu;
  assign mem_wdata   = entry_q.wdata;
  assign mem_pc      = entry_q.pc;
  assign mem_jmpsrc  = entry_q.jmpsrc;
  assign mem_memen   = entry_q.memen;
  assign mem_memwr   = entry_q.memwr;
  assign mem_halt    = entry_q.halt;
  assign mem_brchcnd = entry_q.brchcnd;
  assign mem_alujmp  = entry_q.alujmp;
  assign mem_setrd   = entry_q.setrd;
  assign mem_regsrc  = entry_q.regsrc;
  assign mem_regwr   = entry_q.regwr;
  assign mem_wreg    = entry_q.wreg;
  assign halted      = halted_q;
  assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
module tb_ex_mem_reg;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         stall, flush;
  logic         ex_valid;
  logic [W-1:0] ex_alu, ex_wdata, ex_pc, ex_jmpsrc;
  logic         ex_memen, ex_memwr, ex_halt, ex_brchcnd, ex_alujmp, ex_setrd, ex_regsrc;
  logic         ex_regwr;
  logic [2:0]   ex_wreg;
  logic         mem_valid;
  logic [W-1:0] mem_alu, mem_wdata, mem_pc, mem_jmpsrc;
  logic         mem_memen, mem_memwr, mem_halt, mem_brchcnd, mem_alujmp, mem_setrd;
  logic         mem_regsrc, mem_regwr;
  logic [2:0]   mem_wreg;
  logic         halted;
  logic [15:0]  stall_cnt;

  int checks   = 0;
  int failures = 0;

  ex_mem_reg #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_alu(ex_alu), .ex_wdata(ex_wdata), .ex_pc(ex_pc),
    .ex_jmpsrc(ex_jmpsrc), .ex_memen(ex_memen), .ex_memwr(ex_memwr), .ex_halt(ex_halt),
    .ex_brchcnd(ex_brchcnd), .ex_alujmp(ex_alujmp), .ex_setrd(ex_setrd),
    .ex_regsrc(ex_regsrc), .ex_regwr(ex_regwr), .ex_wreg(ex_wreg),
    .mem_valid(mem_valid), .mem_alu(mem_alu), .mem_wdata(mem_wdata), .mem_pc(mem_pc),
    .mem_jmpsrc(mem_jmpsrc), .mem_memen(mem_memen), .mem_memwr(mem_memwr),
    .mem_halt(mem_halt), .mem_brchcnd(mem_brchcnd), .mem_alujmp(mem_alujmp),
    .mem_setrd(mem_setrd), .mem_regsrc(mem_regsrc), .mem_regwr(mem_regwr),
    .mem_wreg(mem_wreg), .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Table rows: ex_wdata/pc/jmpsrc are driven equal to ex_alu and ex_wreg to ex_alu[2:0],
  // the remaining control bits equal to ex_memen, so one expected value covers each group.
  typedef struct {
    string       name;
    logic        stall, flush, valid, halt, memen, regwr;
    logic [15:0] alu;
    logic        e_valid, e_halt, e_halted, e_memen, e_regwr;
    logic [15:0] e_alu, e_cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_all(input logic v);
    ex_valid = v; ex_alu = {W{v}}; ex_wdata = {W{v}}; ex_pc = {W{v}}; ex_jmpsrc = {W{v}};
    ex_memen = v; ex_memwr = v; ex_halt = v; ex_brchcnd = v; ex_alujmp = v;
    ex_setrd = v; ex_regsrc = v; ex_regwr = v; ex_wreg = {3{v}};
  endtask

  task automatic chk_bubble(input string name, input logic [15:0] pc_exp);
    chk({name, ".valid"}, mem_valid, 0);
    chk({name, ".alu"}, mem_alu, 0);
    chk({name, ".wdata"}, mem_wdata, 0);
    chk({name, ".pc"}, mem_pc, pc_exp);
    chk({name, ".jmpsrc"}, mem_jmpsrc, 0);
    chk({name, ".ctrl"}, {mem_memen, mem_memwr, mem_halt, mem_brchcnd, mem_alujmp,
                          mem_setrd, mem_regsrc, mem_regwr}, 0);
    chk({name, ".wreg"}, mem_wreg, 0);
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    stall = v.stall; flush = v.flush; ex_valid = v.valid; ex_halt = v.halt;
    ex_memen = v.memen; ex_memwr = v.memen; ex_brchcnd = v.memen; ex_alujmp = v.memen;
    ex_setrd = v.memen; ex_regsrc = v.memen; ex_regwr = v.regwr;
    ex_alu = v.alu; ex_wdata = v.alu; ex_pc = v.alu; ex_jmpsrc = v.alu; ex_wreg = v.alu[2:0];
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.name, ".valid"}, mem_valid, e.e_valid);
    chk({e.name, ".alu"}, mem_alu, e.e_alu);
    chk({e.name, ".words"}, {mem_wdata, mem_pc, mem_jmpsrc}, {e.e_alu, e.e_alu});
    chk({e.name, ".jmpsrc"}, mem_jmpsrc, e.e_alu);
    chk({e.name, ".wreg"}, mem_wreg, e.e_alu[2:0]);
    chk({e.name, ".halt"}, mem_halt, e.e_halt);
    chk({e.name, ".ctrl"}, {mem_memen, mem_memwr, mem_brchcnd, mem_alujmp, mem_setrd,
                            mem_regsrc}, {6{e.e_memen}});
    chk({e.name, ".regwr"}, mem_regwr, e.e_regwr);
    chk({e.name, ".halted"}, halted, e.e_halted);
    chk({e.name, ".cnt"}, stall_cnt, e.e_cnt);
  endtask

  task automatic add(input string n, input logic s, f, v, h, me, rw, input logic [15:0] a,
                     input logic ev, eh, ehd, eme, erw, input logic [15:0] ea, ec);
    vec_t r;
    r.name = n; r.stall = s; r.flush = f; r.valid = v; r.halt = h; r.memen = me;
    r.regwr = rw; r.alu = a; r.e_valid = ev; r.e_halt = eh; r.e_halted = ehd;
    r.e_memen = eme; r.e_regwr = erw; r.e_alu = ea; r.e_cnt = ec;
    vecs.push_back(r);
  endtask

  initial begin
    //   name      st fl v  h  me rw alu       ev eh hd me rw e_alu     cnt
    add("loadA",   0, 0, 1, 0, 0, 0, 16'h00AA, 1, 0, 0, 0, 0, 16'h00AA, 16'd0);
    add("stall1",  1, 0, 1, 0, 1, 1, 16'h00BB, 1, 0, 0, 0, 0, 16'h00AA, 16'd1);
    add("stall2",  1, 0, 1, 0, 1, 1, 16'h00BB, 1, 0, 0, 0, 0, 16'h00AA, 16'd2);
    add("stall3",  1, 0, 1, 0, 1, 1, 16'h00BB, 1, 0, 0, 0, 0, 16'h00AA, 16'd3);
    add("stflush", 1, 1, 1, 0, 1, 1, 16'h00BB, 0, 0, 0, 0, 0, 16'h0000, 16'd3);
    add("stbub",   1, 0, 1, 0, 1, 1, 16'h00BB, 0, 0, 0, 0, 0, 16'h0000, 16'd3);
    add("loadB",   0, 0, 1, 0, 1, 1, 16'h0C3D, 1, 0, 0, 1, 1, 16'h0C3D, 16'd3);
    add("invalid", 0, 0, 0, 0, 1, 1, 16'h7777, 0, 0, 0, 0, 0, 16'h0000, 16'd3);
    add("halt",    0, 0, 1, 1, 0, 0, 16'h0003, 1, 1, 1, 0, 0, 16'h0003, 16'd3);
    add("hstall",  1, 0, 1, 0, 0, 1, 16'h5555, 1, 1, 1, 0, 0, 16'h0003, 16'd4);
    add("hblk1",   0, 0, 1, 0, 0, 1, 16'h5555, 0, 0, 1, 0, 0, 16'h0000, 16'd4);
    add("hblk2",   0, 0, 1, 0, 0, 1, 16'h5555, 0, 0, 1, 0, 0, 16'h0000, 16'd4);
    add("hblk3",   0, 0, 1, 0, 0, 1, 16'h5555, 0, 0, 1, 0, 0, 16'h0000, 16'd4);
    add("hblk4",   0, 0, 1, 1, 1, 1, 16'h5555, 0, 0, 1, 0, 0, 16'h0000, 16'd4);
    add("hflush",  0, 1, 1, 0, 1, 1, 16'h5555, 0, 0, 1, 0, 0, 16'h0000, 16'd4);

    // Load all-ones (including a halt), then assert reset between edges.
    rst = 1'b0; stall = 1'b0; flush = 1'b0; set_all(1'b1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("ones.valid", mem_valid, 1);
    chk("ones.halted", halted, 1);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk_bubble("rst", 16'h0000);
    chk("rst.halted", halted, 0);
    chk("rst.cnt", stall_cnt, 0);
    @(posedge clk); #1;
    chk_bubble("rst_hold", 16'h0000);

    // Full-field load.
    @(negedge clk);
    rst = 1'b1; set_all(1'b0);
    ex_valid = 1; ex_alu = 16'h1234; ex_wdata = 16'hBEEF; ex_pc = 16'h0042;
    ex_jmpsrc = 16'hFFFE; ex_wreg = 3'd5; ex_memwr = 1;
    @(posedge clk); #1;
    chk("ld.valid", mem_valid, 1);
    chk("ld.alu", mem_alu, 16'h1234);
    chk("ld.wdata", mem_wdata, 16'hBEEF);
    chk("ld.pc", mem_pc, 16'h0042);
    chk("ld.jmpsrc", mem_jmpsrc, 16'hFFFE);
    chk("ld.wreg", mem_wreg, 5);
    chk("ld.ctrl", {mem_memen, mem_memwr, mem_halt, mem_brchcnd, mem_alujmp, mem_setrd,
                    mem_regsrc, mem_regwr}, 8'b0100_0000);
    chk("ld.halted", halted, 0);

    foreach (vecs[i]) apply(vecs[i]);

    // Reset while halted clears the latch immediately.
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("hrst.halted", halted, 0);
    chk("hrst.cnt", stall_cnt, 0);
    chk_bubble("hrst", 16'h0000);

    // Saturation: one valid entry held under stall for 65540 edges.
    @(negedge clk);
    rst = 1'b1; stall = 0; flush = 0; set_all(1'b0); ex_valid = 1; ex_alu = 16'h0001;
    @(negedge clk);
    stall = 1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat.fffe", stall_cnt, 16'hFFFE);
    @(posedge clk); #1;
    chk("sat.ffff", stall_cnt, 16'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("sat.nowrap", stall_cnt, 16'hFFFF);
    chk("sat.held", mem_alu, 16'h0001);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("satrst.cnt", stall_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

EX/MEM pipeline register that sits directly upstream of the memory stage and captures everything the memory stage consumes: store data, ALU result/address, PC+2, jump offset, memory controls, branch/jump selects, and writeback controls. Supports stall (hold), flush (bubble insertion) and a sticky halt latch that blocks further work once a halt reaches memory. Also keeps a saturating count of stalled cycles for performance debug.

## Interface
- WIDTH, 16, datapath width of all word fields
- RESET_PC, 16'h0000, value of mem_pc after reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- stall  in  1  memory stage not ready; hold all registered outputs
- flush  in  1  kill incoming EX entry; load a bubble instead
- ex_valid  in  1  EX entry is a real instruction
- ex_alu  in  WIDTH  ALU result / memory address
- ex_wdata  in  WIDTH  store data
- ex_pc  in  WIDTH  PC+2 of the instruction
- ex_jmpsrc  in  WIDTH  branch/jump offset
- ex_memen, ex_memwr, ex_halt, ex_brchcnd, ex_alujmp, ex_setrd, ex_regsrc, ex_regwr  in  1 each  control bits
- ex_wreg  in  3  destination register index
- mem_valid  out  1  registered ex_valid (after bubble/halt rules)
- mem_alu, mem_wdata, mem_pc, mem_jmpsrc  out  WIDTH  registered word fields
- mem_memen, mem_memwr, mem_halt, mem_brchcnd, mem_alujmp, mem_setrd, mem_regsrc, mem_regwr  out  1  registered control bits
- mem_wreg  out  3  registered destination index
- halted  out  1  sticky: a valid halt has entered the memory stage
- stall_cnt  out  16  saturating count of cycles with stall=1 and mem_valid=1

## Operation
- Per-edge action, priority order: reset > flush > stall > halted-block > load.
- Reset (rst=0, any time, asynchronous): every output 0 except mem_pc = RESET_PC; halted=0; stall_cnt=0.
- Flush: load bubble regardless of stall. Bubble = mem_valid 0, all control outputs 0, all word fields 0, mem_wreg 0. halted unchanged.
- Stall (flush=0): every mem_* output holds; halted holds.
- Halted-block (halted=1, no flush/stall): load bubble; ex_* ignored.
- Load: mem_valid <= ex_valid. If ex_valid=0, load bubble (controls and data zeroed). If ex_valid=1, all ex_* fields copied verbatim.
- Halt latch: halted <= 1 on an edge that performs a Load with ex_valid=1 and ex_halt=1. Cleared only by reset. The halt entry itself occupies the register normally; mem_halt is high while it is held (one cycle unless stalled).
- Control outputs are never asserted with mem_valid=0 (invariant).
- stall_cnt: +1 on each edge where stall=1, flush=0 and mem_valid=1; saturates at 16'hFFFF; never wraps. Not incremented during reset.
- Word fields have no arithmetic; widths pass through unchanged.

## Timing
- Latency: ex_* sampled at edge N visible on mem_* after edge N (one cycle).
- All outputs are register outputs; no combinational path from any input to any output.
- rst deassertion is taken synchronously by downstream logic; first capture occurs on the first rising edge with rst=1.
- Flush and stall in same cycle: bubble loaded (flush wins); stall_cnt not incremented.
- Halt loaded at edge N: mem_halt=1 and halted=1 after N; at edge N+1 (no stall) a bubble loads, mem_halt=0, halted stays 1.
- Stall on the halt entry: mem_halt stays 1 for every stalled cycle.
- Reset mid-stall or mid-halt: all state cleared immediately, halted=0.

## Test plan
- Reset: drive rst=0 with all ex_* = all-ones -> all mem_* 0, mem_pc=16'h0000, halted=0, stall_cnt=0, asynchronously before next edge.
- Load: ex_valid=1, ex_alu=16'h1234, ex_wdata=16'hBEEF, ex_pc=16'h0042, ex_jmpsrc=16'hFFFE, ex_wreg=5, ex_memwr=1 -> one edge later identical values on mem_*, mem_valid=1.
- Stall/flush: load entry A (ex_alu=16'h00AA), assert stall 3 cycles with ex_alu=16'h00BB -> mem_alu stays 16'h00AA, stall_cnt=3; then stall=1, flush=1 -> bubble, stall_cnt stays 3.
- Halt: load valid ex_halt=1, then ex_valid=1 ex_regwr=1 ex_alu=16'h5555 for 4 cycles -> mem_halt=1 one cycle, halted=1 thereafter, mem_valid=0, mem_regwr=0, mem_alu=0; rst=0 clears halted.
- Invalid entry: ex_valid=0 with ex_memen=1, ex_regwr=1, ex_alu=16'h7777 -> mem_valid=0, mem_memen=0, mem_regwr=0, mem_alu=0.
- Saturation: preload stall_cnt near max (hold stall with valid entry 65,540 cycles) -> stall_cnt reads 16'hFFFF, no wrap.
